dec38_led_seq: RTL and testbench
================================

Name: dec38_led_seq

Overview:
- Sequential 3-to-8 decoder that sits at the display end of the switch-encoder path.
- Accepts a 3-bit code through a valid/ready handshake, latches it, and drives a registered one-hot LED pattern.
- The pattern is held for a fixed number of cycles, then blinks out and clears.
- Gives the board a timed, self-clearing indication of the last encoded switch.

Parameters:
- HOLD_CYC, 16: cycles the one-hot pattern is held solid after accept; legal range ≥1.
- BLINK_DIV, 4: cycles per blink phase (off or on); legal range ≥1.
- BLINK_TOGGLES, 6: number of blink phases; must be even and ≥2.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- en_i  input  1  block enable; low aborts any display.
- valid_i  input  1  code_i is valid this cycle.
- code_i  input  3  binary code to decode.
- ready_o  output  1  combinational; equals en_i AND (state != BLINK).
- led_o  output  8  registered one-hot (or zero) LED drive.
- code_o  output  3  registered copy of the last accepted code.
- gs_o  output  1  registered; 1 while state is HOLD or BLINK.

Behaviour:
- States: IDLE, HOLD, BLINK.
- Reset: rst=1 at a rising edge gives state=IDLE, led_o=0x00, code_o=0, gs_o=0, and all counters cleared. rst has priority over every other input. Reset mid-HOLD or mid-BLINK clears the outputs on the next cycle.
- Accept: occurs at an edge where valid_i & ready_o & en_i are all 1.
- Accept from IDLE or HOLD:
  - The next cycle enters HOLD with led_o = 8'b1 << code_i, code_o = code_i, gs_o = 1.
  - The hold counter loads HOLD_CYC-1.
  - An accept while already in HOLD restarts the hold with the new code. No idle gap occurs; led_o switches directly on the next cycle.
- HOLD:
  - The counter decrements each cycle.
  - At the edge where counter==0 and no accept occurs, the block leaves HOLD. It goes to BLINK if DEC38_BLINK_EN is defined, otherwise to IDLE.
  - led_o is therefore solid for exactly HOLD_CYC cycles, starting the cycle after accept.
- BLINK:
  - ready_o=0, so valid_i is ignored and nothing is queued.
  - Phases alternate off/on, starting with off. Each phase lasts BLINK_DIV cycles, for BLINK_TOGGLES phases in total.
  - Off phase: led_o=0x00. On phase: led_o = 8'b1 << code_o.
  - After the last (on) phase the block enters IDLE with led_o=0x00 and gs_o=0. BLINK therefore lasts BLINK_DIV*BLINK_TOGGLES cycles.
- IDLE: led_o=0x00 and gs_o=0. code_o keeps the last accepted value.
- en_i low at an edge, in any state, is a synchronous abort:
  - Next cycle: state IDLE, led_o=0x00, gs_o=0, code_o retained.
  - ready_o is 0 while en_i is low.
  - en_i has priority over accept and below rst.
- Simultaneous events in HOLD:
  - valid_i with counter==0 in the same cycle: the accept wins and HOLD restarts.
  - en_i=0 and valid_i=1 in the same cycle: the abort wins.
- Width rules:
  - Counters are $clog2(max)+1 bits wide.
  - The blink phase counter counts from BLINK_TOGGLES-1 down to 0.
  - All compares are unsigned. No wrap-around is permitted; counters stop at 0.
- Illegal parameters (odd BLINK_TOGGLES, zero values) are rejected by an elaboration-time check.

Optional Feature:
- Macro: DEC38_BLINK_EN.
- Defined: the BLINK state, the phase counter and the blink divider are compiled in, with behaviour as above.
- Undefined:
  - No BLINK logic is compiled in.
  - HOLD exits directly to IDLE when the counter reaches 0.
  - ready_o reduces to en_i.
  - BLINK_DIV and BLINK_TOGGLES are unused.
  - The abort, reset and restart rules are unchanged.

Test Plan:
- Reset: hold rst=1 for 2 cycles with valid_i=1, code_i=7 → led_o=0x00, code_o=0, gs_o=0 throughout; ready_o=en_i after release.
- Accept and hold (macro defined): en_i=1, valid_i=1, code_i=3 for one cycle → led_o=0x08 for exactly 16 cycles, then 0x00/0x08 alternating every 4 cycles (off first, 6 phases, 24 cycles), then IDLE with gs_o=0.
- Restart in HOLD: accept code 3, then 5 cycles later accept code 5 → led_o goes from 0x08 to 0x20 the next cycle, then is solid 0x20 for 16 cycles; code_o=5.
- Ignored during BLINK: pulse valid_i with code_i=1 mid-BLINK → ready_o=0, led_o and code_o unchanged, blink sequence completes normally.
- Abort: drop en_i mid-HOLD with valid_i=1, code_i=6 → next cycle led_o=0x00, gs_o=0, code_o keeps the prior value, ready_o=0.
- Macro undefined: accept code 0 → led_o=0x01 for 16 cycles, then 0x00 with no blink; ready_o stays 1 throughout.

Source files
------------

// File: rtl/dec38_led_seq.sv
// Sequential 3-to-8 LED decoder: latches a code, holds it solid, then clears.
// Optional blink-out tail after the hold is compiled in with DEC38_BLINK_EN.
module dec38_led_seq #(
   parameter int HOLD_CYC      = 16,
   parameter int BLINK_DIV     = 4,
   parameter int BLINK_TOGGLES = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       valid_i,
   input  logic [2:0] code_i,
   output logic       ready_o,
   output logic [7:0] led_o,
   output logic [2:0] code_o,
   output logic       gs_o
);

   localparam int HW = $clog2(HOLD_CYC) + 1;
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC - 1);

   generate
      if (HOLD_CYC < 1 || BLINK_DIV < 1 || BLINK_TOGGLES < 2 ||
          (BLINK_TOGGLES % 2) != 0) begin : g_bad_param
         $error("dec38_led_seq: illegal parameter value");
      end
   endgenerate

`ifdef DEC38_BLINK_EN
   localparam int DW = $clog2(BLINK_DIV) + 1;
   localparam int PW = $clog2(BLINK_TOGGLES) + 1;
   localparam logic [DW-1:0] DIV_LD = DW'(BLINK_DIV - 1);
   localparam logic [PW-1:0] PH_LD  = PW'(BLINK_TOGGLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1
`ifdef DEC38_BLINK_EN
      ,
      BLINK = 2'd2
`endif
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [HW-1:0]   hold_cnt;
   logic [HW-1:0]   hold_n;
   logic [7:0]      led_n;
   logic [2:0]      code_n;
   logic            gs_n;
   logic            accept;
`ifdef DEC38_BLINK_EN
   logic [DW-1:0]   div_cnt;
   logic [DW-1:0]   div_n;
   logic [PW-1:0]   ph_cnt;
   logic [PW-1:0]   ph_n;
`endif

`ifdef DEC38_BLINK_EN
   assign ready_o = en_i & (state != BLINK);
`else
   assign ready_o = en_i;
`endif

   assign accept = valid_i & ready_o & en_i;

   // Next state, counters and registered outputs; abort beats accept.
   always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      led_n   = led_o;
      code_n  = code_o;
      gs_n    = gs_o;
`ifdef DEC38_BLINK_EN
      div_n   = div_cnt;
      ph_n    = ph_cnt;
`endif
      if (!en_i) begin
         state_n = IDLE;
         hold_n  = '0;
         led_n   = 8'h00;
         gs_n    = 1'b0;
`ifdef DEC38_BLINK_EN
         div_n   = '0;
         ph_n    = '0;
`endif
      end else if (accept) begin
         state_n = HOLD;
         hold_n  = HOLD_LD;
         led_n   = 8'd1 << code_i;
         code_n  = code_i;
         gs_n    = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               led_n = 8'h00;
               gs_n  = 1'b0;
            end
            HOLD: begin
               if (hold_cnt == '0) begin
`ifdef DEC38_BLINK_EN
                  state_n = BLINK;
                  div_n   = DIV_LD;
                  ph_n    = PH_LD;
                  led_n   = 8'h00;
                  gs_n    = 1'b1;
`else
                  state_n = IDLE;
                  led_n   = 8'h00;
                  gs_n    = 1'b0;
`endif
               end else begin
                  hold_n = hold_cnt - HW'(1);
               end
            end
`ifdef DEC38_BLINK_EN
            BLINK: begin
               if (div_cnt == '0) begin
                  if (ph_cnt == '0) begin
                     state_n = IDLE;
                     led_n   = 8'h00;
                     gs_n    = 1'b0;
                  end else begin
                     // Odd remaining count is an off phase, so the next
                     // phase (one fewer) is on when the current is odd.
                     ph_n  = ph_cnt - PW'(1);
                     div_n = DIV_LD;
                     led_n = ph_cnt[0] ? (8'd1 << code_o) : 8'h00;
                  end
               end else begin
                  div_n = div_cnt - DW'(1);
               end
            end
`endif
            default: begin
               state_n = IDLE;
               led_n   = 8'h00;
               gs_n    = 1'b0;
            end
         endcase
      end
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         led_o    <= 8'h00;
         code_o   <= 3'd0;
         gs_o     <= 1'b0;
`ifdef DEC38_BLINK_EN
         div_cnt  <= '0;
         ph_cnt   <= '0;
`endif
      end else begin
         state    <= state_n;
         hold_cnt <= hold_n;
         led_o    <= led_n;
         code_o   <= code_n;
         gs_o     <= gs_n;
`ifdef DEC38_BLINK_EN
         div_cnt  <= div_n;
         ph_cnt   <= ph_n;
`endif
      end
   end

endmodule

// File: tb/tb_dec38_led_seq.sv
// Testbench for dec38_led_seq: elapsed-time display model plus directed vectors.
// Follows DEC38_BLINK_EN the same way as the design.
`timescale 1ns/1ps
module tb_dec38_led_seq;

   localparam int HOLD_CYC      = 16;
   localparam int BLINK_DIV     = 4;
   localparam int BLINK_TOGGLES = 6;
`ifdef DEC38_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif
   localparam int TOTAL = HOLD_CYC + (BLINK_ON ? BLINK_DIV * BLINK_TOGGLES : 0);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_i = 1'b1;
   logic       valid_i = 1'b1;
   logic [2:0] code_i = 3'd7;
   logic       ready_o;
   logic [7:0] led_o;
   logic [2:0] code_o;
   logic       gs_o;

   dec38_led_seq #(
      .HOLD_CYC(HOLD_CYC),
      .BLINK_DIV(BLINK_DIV),
      .BLINK_TOGGLES(BLINK_TOGGLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en_i(en_i),
      .valid_i(valid_i),
      .code_i(code_i),
      .ready_o(ready_o),
      .led_o(led_o),
      .code_o(code_o),
      .gs_o(gs_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Model: cycles elapsed since the last accept decide the display.
   bit         armed = 1'b0;
   bit         m_active = 1'b0;
   int         m_el = 0;
   logic [2:0] m_code = 3'd0;

   function automatic bit m_blink();
      return m_active && (m_el > HOLD_CYC);
   endfunction

   function automatic logic [7:0] m_led();
      logic [7:0] one;
      int k;
      one = 8'd1;
      if (!m_active) return 8'h00;
      if (m_el <= HOLD_CYC) return one << m_code;
      k = (m_el - HOLD_CYC - 1) / BLINK_DIV;
      return (k % 2 == 0) ? 8'h00 : (one << m_code);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         armed    <= 1'b1;
         m_active <= 1'b0;
         m_el     <= 0;
         m_code   <= 3'd0;
      end else if (!en_i) begin
         m_active <= 1'b0;
      end else if (valid_i && !m_blink()) begin
         m_active <= 1'b1;
         m_el     <= 1;
         m_code   <= code_i;
      end else if (m_active) begin
         m_el <= m_el + 1;
         if (m_el + 1 > TOTAL) m_active <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         check("model led", led_o, m_led());
         check("model code", {5'b0, code_o}, {5'b0, m_code});
         check("model gs", {7'b0, gs_o}, {7'b0, m_active});
         check("model ready", {7'b0, ready_o}, {7'b0, en_i && !m_blink()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      check("reset led", led_o, 8'h00);
      check("reset code", {5'b0, code_o}, 8'h00);
      check("reset gs", {7'b0, gs_o}, 8'h00);
      rst = 1'b0;
      valid_i = 1'b0;
      code_i = 3'd0;
      tick();
      check("ready after reset", {7'b0, ready_o}, 8'h01);

      valid_i = 1'b1;
      code_i = 3'd3;
      tick();
      valid_i = 1'b0;
      check("accept3 led", led_o, 8'h08);
      check("accept3 code", {5'b0, code_o}, 8'h03);
      check("accept3 gs", {7'b0, gs_o}, 8'h01);
      repeat (15) tick();
      check("hold last cycle", led_o, 8'h08);
      tick();
      check("hold end led", led_o, 8'h00);
      check("hold end gs", {7'b0, gs_o}, {7'b0, BLINK_ON});
`ifdef DEC38_BLINK_EN
      repeat (4) tick();
      check("first on phase", led_o, 8'h08);
      repeat (20) tick();
      check("blink done gs", {7'b0, gs_o}, 8'h00);
`endif
      repeat (30) tick();

      valid_i = 1'b1;
      code_i = 3'd3;
      tick();
      valid_i = 1'b0;
      repeat (4) tick();
      valid_i = 1'b1;
      code_i = 3'd5;
      tick();
      valid_i = 1'b0;
      check("restart led", led_o, 8'h20);
      check("restart code", {5'b0, code_o}, 8'h05);
      repeat (15) tick();
      check("restart hold last", led_o, 8'h20);
      tick();
      check("restart hold end", led_o, 8'h00);
      repeat (30) tick();

      valid_i = 1'b1;
      code_i = 3'd1;
      tick();
      valid_i = 1'b0;
      repeat (15) tick();
      valid_i = 1'b1;
      code_i = 3'd7;
      tick();
      valid_i = 1'b0;
      check("accept at zero led", led_o, 8'h80);
      repeat (2) tick();
      en_i = 1'b0;
      valid_i = 1'b1;
      code_i = 3'd6;
      tick();
      check("abort led", led_o, 8'h00);
      check("abort gs", {7'b0, gs_o}, 8'h00);
      check("abort code", {5'b0, code_o}, 8'h07);
      check("abort ready", {7'b0, ready_o}, 8'h00);
      en_i = 1'b1;
      valid_i = 1'b0;
      tick();
      check("ready after abort", {7'b0, ready_o}, 8'h01);

`ifdef DEC38_BLINK_EN
      valid_i = 1'b1;
      code_i = 3'd2;
      tick();
      valid_i = 1'b0;
      repeat (20) tick();
      check("blink ready", {7'b0, ready_o}, 8'h00);
      valid_i = 1'b1;
      code_i = 3'd1;
      tick();
      valid_i = 1'b0;
      check("blink ignore code", {5'b0, code_o}, 8'h02);
      repeat (20) tick();
      check("blink ignore end gs", {7'b0, gs_o}, 8'h00);
`endif

      valid_i = 1'b1;
      code_i = 3'd0;
      tick();
      valid_i = 1'b0;
      check("code0 led", led_o, 8'h01);
      check("code0 ready", {7'b0, ready_o}, 8'h01);
      repeat (15) tick();
      check("code0 hold last", led_o, 8'h01);
      tick();
      check("code0 hold end", led_o, 8'h00);
      repeat (30) tick();

      valid_i = 1'b1;
      code_i = 3'd4;
      tick();
      valid_i = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("midhold reset led", led_o, 8'h00);
      check("midhold reset code", {5'b0, code_o}, 8'h00);
      check("midhold reset gs", {7'b0, gs_o}, 8'h00);
      rst = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
